// File: rtl/multicycle_mem_unit.sv
// -----------------------------------------------------------------------------
// multicycle_mem_unit
//   Unified instruction/data memory for the multicycle RISC-V core. Fetches,
//   loads and stores share one 64-bit-wide array. Each access has a fixed,
//   configurable number of wait states. Only one request is in flight at a
//   time: a valid/ready handshake accepts it, and a one-cycle resp_valid pulse
//   signals completion.
//
// Ports
//   clock       in   1   rising-edge clock
//   reset       in   1   asynchronous, active-high reset (aborts any request)
//   req_valid   in   1   request present
//   req_write   in   1   1 = store doubleword, 0 = load/fetch
//   req_addr    in   64  byte address (low 3 bits must be zero)
//   req_wdata   in   64  store data
//   req_ready   out  1   a request can be accepted this cycle
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  64  read data (0 for writes and misaligned requests)
//   resp_err    out  1   request was misaligned
//   busy        out  1   a request is in flight
// -----------------------------------------------------------------------------
module multicycle_mem_unit #(
    parameter int DEPTH_LOG2    = 10,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // The counter only ever holds latency-1, so clog2(MAX_LAT) bits suffice.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    write_q;
    logic                    misalign_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [63:0]             wdata_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic [63:0]             resp_rdata_q;
    logic                    resp_err_q;
    logic                    busy_q;

    logic [63:0]             mem_q [0:DEPTH-1];

    logic                    accept;
    logic                    last_cycle;
    logic                    mem_we;
    logic                    unused_addr_bits;

    assign accept     = req_valid && req_ready_q;
    assign last_cycle = (state_q == BUSY) && (cnt_q == CNT_ZERO);
    // A store lands only on its completion edge; misaligned stores never land.
    assign mem_we     = last_cycle && write_q && !misalign_q;

    // Address bits above the array wrap silently.
    assign unused_addr_bits = ^req_addr[63:DEPTH_LOG2+3];

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            write_q      <= 1'b0;
            misalign_q   <= 1'b0;
            idx_q        <= {DEPTH_LOG2{1'b0}};
            wdata_q      <= 64'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'h0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 64'h0;
                    resp_err_q   <= 1'b0;
                    if (accept) begin
                        // Latch the request so the requester may change req_* freely.
                        write_q     <= req_write;
                        misalign_q  <= (req_addr[2:0] != 3'b000);
                        idx_q       <= req_addr[DEPTH_LOG2+2:3];
                        wdata_q     <= req_wdata;
                        cnt_q       <= req_write ? WR_CNT : RD_CNT;
                        state_q     <= BUSY;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q      <= RESP;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= misalign_q;
                        resp_rdata_q <= (write_q || misalign_q) ? 64'h0 : mem_q[idx_q];
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= CNT_ZERO;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 64'h0;
                    resp_err_q   <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Storage array write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_multicycle_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_mem_unit
//   Self-checking bench. dut uses the default latencies (read 2, write 1);
//   dut3 uses latency 3 for both and is exercised by the reset-abort scenario.
//   Expected responses are queued when a request is driven and popped when the
//   DUT answers.
// -----------------------------------------------------------------------------
module tb_multicycle_mem_unit;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clock;
    logic        rst;
    logic        rst3;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        req_ready,  resp_valid,  resp_err,  busy;
    logic [63:0] resp_rdata;
    logic        req_ready3, resp_valid3, resp_err3, busy3;
    logic [63:0] resp_rdata3;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    multicycle_mem_unit #(.DEPTH_LOG2(10), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut (
        .clock(clock), .reset(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    multicycle_mem_unit #(.DEPTH_LOG2(10), .READ_LATENCY(3), .WRITE_LATENCY(3)) dut3 (
        .clock(clock), .reset(rst3),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready3), .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
        .resp_err(resp_err3), .busy(busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one request, then count edges until the chosen DUT answers.
    task automatic issue(input bit use3, input logic w, input logic [63:0] a, input logic [63:0] d,
                         output int lat, output logic [63:0] rd, output logic er);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clock);
        #1;
        // Scramble the request bus: the DUT must use its latched copy.
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        lat = -1;
        rd  = 64'h0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (use3 ? resp_valid3 : resp_valid) begin
                lat = i;
                rd  = use3 ? resp_rdata3 : resp_rdata;
                er  = use3 ? resp_err3 : resp_err;
                break;
            end
        end
        req_write = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready !== 1'b1)      begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0)     begin n_bad++; $display("FAIL reset_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 64'h0)    begin n_bad++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got %b want 0", resp_err); end
        n_cmp++; if (busy !== 1'b0)           begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_read_basic();
        int lat; logic [63:0] rd; logic er; exp_t e;
        exp_q.push_back('{64'h0, 1'b0, 1});
        issue(1'b0, 1'b1, 64'h0, 64'h0000_0000_0000_0013, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL preload_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL preload_rdata got %h want %h", rd, e.rdata); end
        @(negedge clock);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_before_read got %b want 1", req_ready); end
        exp_q.push_back('{64'h13, 1'b0, 2});
        issue(1'b0, 1'b0, 64'h0, 64'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL read0_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL read0_rdata got %h want %h", rd, e.rdata); end
        n_cmp++; if (er !== e.err)     begin n_bad++; $display("FAIL read0_err got %b want %b", er, e.err); end
    endtask

    task automatic test_store_load();
        int lat; logic [63:0] rd; logic er; exp_t e;
        exp_q.push_back('{64'h0, 1'b0, 1});
        issue(1'b0, 1'b1, 64'h18, 64'hDEAD_BEEF_0123_4567, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL sd18_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL sd18_rdata got %h want %h", rd, e.rdata); end
        exp_q.push_back('{64'hDEAD_BEEF_0123_4567, 1'b0, 2});
        issue(1'b0, 1'b0, 64'h18, 64'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL ld18_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL ld18_rdata got %h want %h", rd, e.rdata); end
    endtask

    task automatic test_back_to_back();
        int last; int n; exp_t e;
        for (int k = 0; k < 4; k++) exp_q.push_back('{64'hDEAD_BEEF_0123_4567, 1'b0, 2});
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h18;
        last = -1;
        n = 0;
        // Accepts land on cycles 0,3,6,9 and responses on 2,5,8,11.
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            n_cmp++; if (busy !== ~req_ready) begin n_bad++; $display("FAIL b2b_busy_ready cyc %0d busy %b ready %b", c, busy, req_ready); end
            if (c == 0 || c == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_window cyc %0d busy got %b want 1", c, busy); end
            end
            if (resp_valid) begin
                n_cmp++; if (c - last !== 3) begin n_bad++; $display("FAIL b2b_spacing cyc %0d got %0d want 3", c, c - last); end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++; if (resp_rdata !== e.rdata) begin n_bad++; $display("FAIL b2b_rdata got %h want %h", resp_rdata, e.rdata); end
                end
                last = c;
                n++;
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL b2b_count got %0d want 4", n); end
        exp_q.delete();
        // Let the final response cycle retire.
        @(posedge clock);
        #1;
    endtask

    task automatic test_misaligned();
        int lat; logic [63:0] rd; logic er; exp_t e;
        exp_q.push_back('{64'h0, 1'b1, 1});
        issue(1'b0, 1'b1, 64'h1C, 64'hFF, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL mis_sd_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (er !== e.err)     begin n_bad++; $display("FAIL mis_sd_err got %b want %b", er, e.err); end
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL mis_sd_rdata got %h want %h", rd, e.rdata); end
        exp_q.push_back('{64'hDEAD_BEEF_0123_4567, 1'b0, 2});
        issue(1'b0, 1'b0, 64'h18, 64'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL mis_unchanged got %h want %h", rd, e.rdata); end
        n_cmp++; if (er !== e.err)     begin n_bad++; $display("FAIL mis_after_err got %b want %b", er, e.err); end
        exp_q.push_back('{64'h0, 1'b1, 2});
        issue(1'b0, 1'b0, 64'h1C, 64'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL mis_ld_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL mis_ld_rdata got %h want %h", rd, e.rdata); end
        n_cmp++; if (er !== e.err)     begin n_bad++; $display("FAIL mis_ld_err got %b want %b", er, e.err); end
    endtask

    task automatic test_wrap();
        int lat; logic [63:0] rd; logic er; exp_t e;
        exp_q.push_back('{64'h0, 1'b0, 1});
        issue(1'b0, 1'b1, 64'h2008, 64'hAA, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL wrap_sd_lat got %0d want %0d", lat, e.lat); end
        exp_q.push_back('{64'hAA, 1'b0, 2});
        issue(1'b0, 1'b0, 64'h8, 64'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL wrap_rdata got %h want %h", rd, e.rdata); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [63:0] rd; logic er; exp_t e; bit seen;
        @(negedge clock);
        rst3 = 1'b0;
        exp_q.push_back('{64'h0, 1'b0, 3});
        issue(1'b1, 1'b1, 64'h20, 64'h11, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL abort_pre_sd_lat got %0d want %0d", lat, e.lat); end
        // Store that will be aborted one edge after its accept.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'h55;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        n_cmp++; if (busy3 !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %b want 1", busy3); end
        @(posedge clock);
        #1;
        rst3 = 1'b1;
        #1;
        n_cmp++; if (busy3 !== 1'b0)       begin n_bad++; $display("FAIL abort_busy got %b want 0", busy3); end
        n_cmp++; if (req_ready3 !== 1'b1)  begin n_bad++; $display("FAIL abort_ready got %b want 1", req_ready3); end
        n_cmp++; if (resp_valid3 !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b want 0", resp_valid3); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) rst3 = 1'b0;
            if (resp_valid3) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_resp got %b want 0", seen); end
        exp_q.push_back('{64'h11, 1'b0, 3});
        issue(1'b1, 1'b0, 64'h20, 64'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== e.lat)    begin n_bad++; $display("FAIL abort_ld_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.rdata)   begin n_bad++; $display("FAIL abort_ld_rdata got %h want %h", rd, e.rdata); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        rst3      = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        test_reset();
        test_read_basic();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_wrap();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
